// File: rtl/pe_arbiter.sv
// Registered request arbiter: latches request bits into a pending register,
// picks one eligible bit by fixed priority or round-robin, and holds the grant until it is acknowledged.
module pe_arbiter #(
  parameter  int N = 32,
  localparam int W = (N > 2) ? $clog2(N) : 1
) (
  input  logic         clock,
  input  logic         clear_n,
  input  logic [N-1:0] req,
  input  logic [N-1:0] mask,
  input  logic         mode,
  input  logic         ack,
  output logic         valid,
  output logic [W-1:0] code,
  output logic [N-1:0] pending,
  output logic         any_pend
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t       state, state_next;
  logic [N-1:0] eligible;
  logic [N-1:0] clr;
  logic [W-1:0] fixed_sel;
  logic [W-1:0] rr_sel;
  logic [W-1:0] sel;
  logic [W-1:0] last;
  logic         grant_load;
  logic         ack_take;
  int           rr_best;
  int           rr_dist;

  assign eligible = pending & mask;

  always_comb begin
    fixed_sel = '0;
    for (int i = 0; i < N; i++) begin
      if (eligible[i]) fixed_sel = W'(i);
    end
  end

  // Distance from the last grant going downward, so bit last-1 is nearest and last itself is farthest.
  always_comb begin
    rr_sel  = '0;
    rr_best = N + 1;
    rr_dist = 0;
    for (int j = 0; j < N; j++) begin
      rr_dist = (int'(last) + N - j) % N;
      if (rr_dist == 0) rr_dist = N;
      if (eligible[j] && (rr_dist < rr_best)) begin
        rr_best = rr_dist;
        rr_sel  = W'(j);
      end
    end
  end

  assign sel = mode ? rr_sel : fixed_sel;

  always_comb begin
    state_next = state;
    grant_load = 1'b0;
    ack_take   = 1'b0;
    case (state)
      IDLE: begin
        if (|eligible) begin
          grant_load = 1'b1;
          state_next = GRANT;
        end
      end
      GRANT: begin
        if (ack) begin
          ack_take   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N; i++) begin
      clr[i] = ack_take && (code == W'(i));
    end
  end

  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) state <= IDLE;
    else          state <= state_next;
  end

  // A request arriving in the ack cycle wins because req is ORed in after the clear.
  always_ff @(posedge clock or negedge clear_n) begin
    if (!clear_n) begin
      valid    <= 1'b0;
      code     <= '0;
      last     <= '0;
      pending  <= '0;
      any_pend <= 1'b0;
    end else begin
      valid    <= (state_next == GRANT);
      if (grant_load) code <= sel;
      if (ack_take)   last <= code;
      pending  <= (pending & ~clr) | req;
      any_pend <= |eligible;
    end
  end

endmodule

// File: tb/tb_pe_arbiter.sv
// Scoreboard bench for pe_arbiter: a set-based reference model predicts grants and per-cycle status,
// and a monitor compares the DUT against them. A second, 20-line instance covers non-power-of-two sizing.
module tb_pe_arbiter;

  localparam int N = 32;
  localparam int W = 5;

  logic         clock = 1'b0;
  logic         clear_n;
  logic [N-1:0] req, mask;
  logic         mode, ack;
  logic         valid;
  logic [W-1:0] code;
  logic [N-1:0] pending;
  logic         any_pend;

  logic         clear20_n;
  logic [19:0]  req20, mask20;
  logic         mode20, ack20;
  logic         valid20;
  logic [4:0]   code20;
  logic [19:0]  pending20;
  logic         any_pend20;

  always #5 clock = ~clock;

  pe_arbiter #(.N(N)) dut (
    .clock(clock), .clear_n(clear_n), .req(req), .mask(mask), .mode(mode), .ack(ack),
    .valid(valid), .code(code), .pending(pending), .any_pend(any_pend)
  );

  pe_arbiter #(.N(20)) dut20 (
    .clock(clock), .clear_n(clear20_n), .req(req20), .mask(mask20), .mode(mode20), .ack(ack20),
    .valid(valid20), .code(code20), .pending(pending20), .any_pend(any_pend20)
  );

  typedef struct {
    bit           v;
    int           c;
    logic [N-1:0] p;
    bit           a;
  } snap_t;

  int    checks = 0;
  int    errors = 0;
  snap_t status_q[$];
  int    grant_q[$];
  int    grant_log[$];

  logic [N-1:0] m_pend;
  int           m_grant;
  int           m_last;
  int           m_code;
  bit           m_any;
  bit           prev_v;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Walk the search order literally: highest index first, or last-1 downward with wraparound.
  function automatic int pick(input logic [N-1:0] e, input bit rr);
    int idx;
    if (!rr) begin
      for (int i = N - 1; i >= 0; i--) if (e[i]) return i;
    end else begin
      for (int k = 1; k <= N; k++) begin
        idx = (m_last - k + N) % N;
        if (e[idx]) return idx;
      end
    end
    return -1;
  endfunction

  task automatic modelReset();
    m_pend  = '0;
    m_grant = -1;
    m_last  = 0;
    m_code  = 0;
    m_any   = 1'b0;
    status_q.delete();
    grant_q.delete();
  endtask

  task automatic modelStep(input logic [N-1:0] r, input logic [N-1:0] m, input logic md, input logic a);
    logic [N-1:0] e;
    logic [N-1:0] clr_bits;
    snap_t        s;
    int           sel;
    e        = m_pend & m;
    clr_bits = '0;
    if (m_grant >= 0) begin
      if (a) begin
        clr_bits[m_grant] = 1'b1;
        m_last  = m_grant;
        m_grant = -1;
      end
    end else if (e != 0) begin
      sel     = pick(e, md);
      m_grant = sel;
      m_code  = sel;
      grant_q.push_back(sel);
    end
    m_pend = (m_pend & ~clr_bits) | r;
    m_any  = (e != 0);
    s.v = (m_grant >= 0);
    s.c = m_code;
    s.p = m_pend;
    s.a = m_any;
    status_q.push_back(s);
  endtask

  // Called at a falling edge: drives one cycle of inputs, predicts the next rising edge, waits.
  task automatic applyStimulus(input logic [N-1:0] r, input logic [N-1:0] m, input logic md, input logic a);
    req  = r;
    mask = m;
    mode = md;
    ack  = a;
    modelStep(r, m, md, a);
    @(negedge clock);
  endtask

  task automatic doReset();
    clear_n = 1'b0;
    req = '0; mask = '0; mode = 1'b0; ack = 1'b0;
    modelReset();
    grant_log.delete();
    @(negedge clock);
    @(negedge clock);
    checkOutput("reset_valid", valid, 0);
    checkOutput("reset_code", code, 0);
    checkOutput("reset_pending", pending, 0);
    checkOutput("reset_any_pend", any_pend, 0);
    clear_n = 1'b1;
  endtask

  task automatic midReset();
    #2 clear_n = 1'b0;
    #1;
    checkOutput("midreset_valid", valid, 0);
    checkOutput("midreset_pending", pending, 0);
    checkOutput("midreset_code", code, 0);
    modelReset();
    @(negedge clock);
    clear_n = 1'b1;
  endtask

  task automatic runGrants(input logic [N-1:0] r, input logic [N-1:0] m, input logic md, input int count);
    int got;
    bit a;
    got = 0;
    for (int cyc = 0; cyc < count * 8 && got < count; cyc++) begin
      a = (m_grant >= 0);
      if (a) got++;
      applyStimulus(r, m, md, a);
    end
    if (got < count) begin
      checks++;
      errors++;
      $display("[TB] FAIL grant_timeout: got %0d grants, expected %0d", got, count);
    end
  endtask

  task automatic checkLog(input string name, input int exp_codes[$]);
    int actual;
    for (int i = 0; i < exp_codes.size(); i++) begin
      actual = (i < grant_log.size()) ? grant_log[i] : -1;
      checkOutput($sformatf("%s[%0d]", name, i), actual, exp_codes[i]);
    end
  endtask

  initial begin
    snap_t s;
    int    exp_code;
    prev_v = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      if (clear_n !== 1'b1) begin
        prev_v = 1'b0;
        continue;
      end
      if (status_q.size() > 0) begin
        s = status_q.pop_front();
        checkOutput("valid", valid, s.v);
        checkOutput("code", code, s.c);
        checkOutput("pending", pending, s.p);
        checkOutput("any_pend", any_pend, s.a);
      end
      if (valid === 1'b1 && !prev_v) begin
        if (grant_q.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_grant: got code %0d, expected no grant", code);
        end else begin
          exp_code = grant_q.pop_front();
          checkOutput("grant_code", code, exp_code);
          grant_log.push_back(int'(code));
        end
      end
      prev_v = (valid === 1'b1);
    end
  end

  initial begin
    logic [N-1:0] r, m;
    logic         md;
    clear_n = 1'b0;
    req = '0; mask = '0; mode = 1'b0; ack = 1'b0;
    modelReset();

    clear20_n = 1'b0;
    req20 = '0; mask20 = '0; mode20 = 1'b0; ack20 = 1'b0;
    @(negedge clock);
    @(negedge clock);
    clear20_n = 1'b1;
    req20  = 20'h8_0000;
    mask20 = '1;
    @(negedge clock);
    req20 = '0;
    @(negedge clock);
    checkOutput("n20_valid", valid20, 1);
    checkOutput("n20_code", code20, 19);
    checkOutput("n20_pending", pending20, 20'h8_0000);
    #2 clear20_n = 1'b0;
    #1;
    checkOutput("n20_midreset_valid", valid20, 0);
    checkOutput("n20_midreset_pending", pending20, 0);
    @(negedge clock);

    doReset();
    applyStimulus(32'h0000_0100, '1, 1'b0, 1'b0);
    applyStimulus('0, '1, 1'b0, 1'b0);
    checkOutput("single_valid", valid, 1);
    checkOutput("single_code", code, 8);
    applyStimulus('0, '1, 1'b0, 1'b1);
    checkOutput("single_ack_valid", valid, 0);
    checkOutput("single_ack_pending", pending, 0);

    doReset();
    applyStimulus(32'h8000_0011, '1, 1'b0, 1'b0);
    runGrants('0, '1, 1'b0, 3);
    applyStimulus('0, '1, 1'b0, 1'b0);
    applyStimulus('0, '1, 1'b0, 1'b0);
    checkLog("fixed_seq", '{31, 4, 0});
    checkOutput("fixed_any_pend", any_pend, 0);

    doReset();
    runGrants(32'h0000_0111, '1, 1'b1, 5);
    checkLog("rr_seq", '{8, 4, 0, 8, 4});

    doReset();
    applyStimulus(32'h0000_0030, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus('0, 32'h0000_0010, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) applyStimulus('0, '0, 1'b0, 1'b0);
    checkOutput("mask_hold_valid", valid, 1);
    checkOutput("mask_hold_code", code, 4);
    applyStimulus('0, '0, 1'b0, 1'b1);
    applyStimulus('0, 32'h0000_0010, 1'b0, 1'b0);
    applyStimulus('0, 32'h0000_0010, 1'b0, 1'b0);
    checkOutput("mask_after_pending", pending, 32'h0000_0020);
    checkOutput("mask_after_valid", valid, 0);

    doReset();
    applyStimulus(32'h0000_0008, '1, 1'b0, 1'b0);
    applyStimulus('0, '1, 1'b0, 1'b0);
    applyStimulus(32'h0000_0008, '1, 1'b0, 1'b1);
    checkOutput("simul_pending", pending, 32'h0000_0008);
    applyStimulus('0, '1, 1'b0, 1'b0);
    checkOutput("regrant_valid", valid, 1);
    checkOutput("regrant_code", code, 3);
    applyStimulus('0, '1, 1'b0, 1'b1);
    applyStimulus('0, '1, 1'b0, 1'b1);
    applyStimulus('0, '1, 1'b0, 1'b1);
    checkOutput("ignored_ack_valid", valid, 0);
    checkOutput("ignored_ack_code", code, 3);
    checkOutput("ignored_ack_pending", pending, 0);

    applyStimulus(32'h0010_0000, '1, 1'b0, 1'b0);
    applyStimulus('0, '1, 1'b0, 1'b0);
    midReset();

    doReset();
    md = 1'b0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      r = $urandom & $urandom & $urandom;
      m = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
      if ($urandom_range(0, 15) == 0) md = ~md;
      applyStimulus(r, m, md, 1'($urandom_range(0, 1)));
      if (cyc == 200) midReset();
    end

    checkOutput("grant_queue_drained", grant_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pe_arbiter.md
# pe_arbiter

Parametrised, registered successor to the combinational 32-to-5 priority encoder. Latches request bits into a pending register, selects one eligible request by fixed priority or round-robin, and presents its index through a valid/ack handshake. The granted bit clears on acknowledge. Used by the CPU datapath and interrupt logic wherever several sources compete for one encoded select, such as bus-source select and interrupt vectoring.

## Interface
- `N`, default 32: number of request lines, with 2 ≤ N ≤ 64. N does not have to be a power of two.
- `W`, derived as a localparam `max(1, clog2(N))`: width of the code output. It is not overridable.

Ports, clock and reset first:
- `clock`  in  1: single clock. All state changes on the rising edge.
- `clear_n`  in  1: reset, asynchronous and active-low.
- `req`  in  N: request pulses or levels. Bit i is ORed into `pending[i]` every cycle.
- `mask`  in  N: 1 = bit is eligible for selection. Masked bits still latch into pending.
- `mode`  in  1: 0 = fixed priority, highest index wins. 1 = round-robin.
- `ack`  in  1: the consumer accepts the current code. Honoured only while `valid` = 1.
- `valid`  out  1: `code` holds a granted index.
- `code`  out  W: granted index.
- `pending`  out  N: current pending register, driven directly from its flops.
- `any_pend`  out  1: registered flag, 1 when `pending & mask` is non-zero.

## Operation
- **Eligible set:** `E = pending & mask`.
- **Fixed mode (`mode` = 0):** select the highest i with E[i] = 1.
- **Round-robin mode (`mode` = 1):** search order is `last-1`, `last-2`, …, 0, then N-1, …, `last`, modulo N. Select the first i in that order with E[i] = 1.
- **Reset behaviour of `last`:** reset sets `last` = 0, so the first round-robin search order is N-1 down to 0, which is identical to fixed mode.
- **`mode` changes:** take effect at the next selection only. They never change a grant already presented.
- **FSM, IDLE state (reset state):** if E ≠ 0, register the selected index into `code`, set `valid` = 1 and go to GRANT. Otherwise stay in IDLE with `code` unchanged.
- **FSM, GRANT state:** `code` and `valid` are held stable until `ack` = 1. On `ack`:
  - clear `pending[code]`,
  - set `last` = `code`,
  - set `valid` = 0,
  - return to IDLE.
- **Stable grant:** changes to `mask` or `req` during GRANT never alter `code` or revoke `valid`. This holds even if the granted bit becomes masked.
- **Pending update:** each cycle, `pending_next = (pending & ~clr) | req`. `clr` is the one-hot of `code` when an ack is accepted, and 0 otherwise.
- **Ack and request on the same bit in the same cycle:** the request wins, so the bit stays pending.
- **`ack` while `valid` = 0:** ignored, with no state change.
- **Out-of-range indices:** when N is not a power of two, code values ≥ N are never produced.
- **Reset values:**
  - `valid` = 0
  - `code` = 0
  - `pending` = 0
  - `any_pend` = 0
  - `last` = 0
  - FSM = IDLE
- **Reset mid-operation:** asserting `clear_n` low takes effect immediately, without waiting for a clock edge. It drops `valid`, and any grant awaiting ack is discarded.

## Timing
- **Request to grant:** a `req` bit sampled at edge k appears in `pending` after edge k. If the FSM is in IDLE and no other bit wins, `valid` = 1 after edge k+1. Latency is 2 edges.
- **Ack to next grant:** `ack` sampled at edge m gives `valid` = 0 after edge m. The next grant can appear after edge m+1. Maximum throughput is one grant per 2 cycles.
- **`any_pend` timing:** reflects E as registered at the previous edge, so it lags `pending` by one cycle.
- **No combinational paths:** there is no path from any input to any output. All outputs come from flops.

## Test plan
- **Reset and single request:** `clear_n` low, then release. All outputs read 0. Pulse `req`=32'h0000_0100 for one cycle with `mask` all 1s → `valid` = 1 with `code` = 8 two edges after the request. `ack` for one cycle → `valid` = 0 and `pending` = 0.
- **Fixed priority:** `req` = 32'h8000_0011 in one cycle, `mode` = 0, ack each grant → `code` sequence is 31, 4, 0, then `any_pend` = 0.
- **Round-robin:** `mode` = 1, hold `req` = 32'h0000_0111 continuously and ack every grant → `code` sequence is 8, 4, 0, 8, 4. Every bit is re-granted, with no starvation.
- **Masking and stable grant:** `pending` = 32'h0000_0030 and `mask` = 32'h0000_0010 → `code` = 4. Set `mask` = 0 during GRANT → `code` stays 4 and `valid` stays 1 until `ack`. After the ack, `pending` = 32'h0000_0020 and no new grant is made.
- **Simultaneous and ignored ack:** grant `code` = 3 with `req[3]` = 1 in the ack cycle → `pending[3]` stays 1 and bit 3 is granted again. Pulse `ack` while `valid` = 0 → no state change.
- **Non-power-of-two and mid-op reset:** N = 20, W = 5, `req[19]` → `code` = 19. Pull `clear_n` low while in GRANT → `valid` and `pending` go to 0 at once, before any clock edge.
